// File: rtl/vector_unit_seq_if.sv
// Instruction handshake and retire-status bundle for vector_unit_seq.
interface vector_unit_seq_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W+4:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              done;
  logic              err;

  modport master (output instr, output instr_valid, input instr_ready, input done, input err);
  modport slave  (input instr, input instr_valid, output instr_ready, output done, output err);
endinterface

// File: rtl/vector_unit_seq.sv
// Four-register vector unit: sequenced LOAD/STORE over a private single-port
// memory, lane-parallel ADD/MUL/SUB into A3/A4, done/err retire status.
module vector_unit_seq #(
  parameter int LANE_W = 32,
  parameter int LANES  = 16,
  parameter int ADDR_W = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  vector_unit_seq_if.slave        bus,
  output logic [LANE_W*LANES-1:0] A1,
  output logic [LANE_W*LANES-1:0] A2,
  output logic [LANE_W*LANES-1:0] A3,
  output logic [LANE_W*LANES-1:0] A4
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_EXEC} state_e;
  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_MUL   = 3'b011,
    OP_SUB   = 3'b100
  } op_e;

  state_e             state_q;
  op_e                op_q;
  logic [1:0]         rsel_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   cnt_q;
  vec_t               buf_q;
  vec_t               vreg_q [4];
  logic               done_q;
  logic               err_q;
  logic [LANE_W-1:0]  mem_q [DEPTH];

  op_e                op_in;
  logic [1:0]         rsel_in;
  logic [ADDR_W-1:0]  addr_in;
  logic               accept;
  logic               last_elem;
  logic [ADDR_W-1:0]  mem_addr;
  logic [LANE_W-1:0]  rd_data;
  vec_t               load_vec;
  vec_t               alu_lo;
  vec_t               alu_hi;
  logic [LANE_W-1:0]  alu_a;
  logic [LANE_W-1:0]  alu_b;
  logic [LANE_W:0]    alu_sum;
  logic [2*LANE_W-1:0] alu_prod;

  assign op_in   = op_e'(bus.instr[ADDR_W+4 -: 3]);
  assign rsel_in = bus.instr[ADDR_W+1 -: 2];
  assign addr_in = bus.instr[ADDR_W-1:0];

  assign bus.instr_ready = (state_q == S_IDLE);
  assign accept          = bus.instr_valid && (state_q == S_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;

  assign last_elem = (cnt_q == CNT_W'(LANES - 1));
  // Address wraps naturally at DEPTH because the sum is truncated to ADDR_W.
  assign mem_addr  = addr_q + ADDR_W'(cnt_q);
  assign rd_data   = mem_q[mem_addr];

  // Last element bypasses the buffer so the commit edge writes the full vector.
  always_comb begin
    load_vec        = buf_q;
    load_vec[cnt_q] = rd_data;
  end

  always_comb begin
    alu_lo   = '0;
    alu_hi   = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_sum  = '0;
    alu_prod = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      alu_a    = vreg_q[0][k];
      alu_b    = vreg_q[1][k];
      alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
      alu_prod = {{LANE_W{1'b0}}, alu_a} * {{LANE_W{1'b0}}, alu_b};
      case (op_q)
        OP_ADD: begin
          alu_lo[k] = alu_sum[LANE_W-1:0];
          alu_hi[k] = LANE_W'(alu_sum[LANE_W]);
        end
        OP_MUL: begin
          alu_lo[k] = alu_prod[LANE_W-1:0];
          alu_hi[k] = alu_prod[2*LANE_W-1:LANE_W];
        end
        OP_SUB: begin
          alu_lo[k] = alu_a - alu_b;
          alu_hi[k] = (alu_a < alu_b) ? '1 : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      rsel_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      for (int unsigned r = 0; r < 4; r++) vreg_q[r] <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            rsel_q  <= rsel_in;
            addr_q  <= addr_in;
            cnt_q   <= '0;
            state_q <= (op_in == OP_LOAD || op_in == OP_STORE) ? S_MEM : S_EXEC;
          end
        end
        S_MEM: begin
          if (op_q == OP_LOAD) buf_q[cnt_q] <= rd_data;
          cnt_q <= cnt_q + 1'b1;
          if (last_elem) begin
            if (op_q == OP_LOAD) vreg_q[rsel_q] <= load_vec;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_ADD, OP_MUL, OP_SUB: begin
              vreg_q[2] <= alu_lo;
              vreg_q[3] <= alu_hi;
            end
            default: err_q <= 1'b1;
          endcase
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory has no reset; an aborted STORE keeps the words already written.
  always_ff @(posedge clk) begin
    if (state_q == S_MEM && op_q == OP_STORE) mem_q[mem_addr] <= vreg_q[rsel_q][cnt_q];
  end

  assign A1 = vreg_q[0];
  assign A2 = vreg_q[1];
  assign A3 = vreg_q[2];
  assign A4 = vreg_q[3];
endmodule

// File: doc/vector_unit_seq.md
Name: vector_unit_seq

Overview:
Parametrised, multi-cycle successor to the current 4-register vector processor. Holds four vector registers A1..A4, each LANES elements of LANE_W bits, plus a private DEPTH-word data memory. Adds a valid/ready instruction handshake, sequenced per-element LOAD/STORE over a single-port memory, address wrap-around, a SUB mode, and done/err status. Sits behind the instruction sequencer; A1..A4 are exported for observation.

Parameters:
LANE_W, 32, bits per vector element and per memory word
LANES, 16, elements per vector register (register width VW = LANE_W*LANES)
ADDR_W, 9, memory address width; DEPTH = 2**ADDR_W words

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
instr  in  5+ADDR_W  {op[2:0], rsel[1:0], addr[ADDR_W-1:0]}
instr_valid  in  1  instr is presented
instr_ready  out  1  unit accepts instr this cycle
done  out  1  one-cycle pulse when an instruction retires
err  out  1  one-cycle pulse, coincident with done, for illegal opcode
A1, A2, A3, A4  out  VW each  vector registers 0..3, element k at bits [k*LANE_W +: LANE_W]

Behaviour:
- Reset (async, active-high): A1..A4 = 0, state IDLE, done = 0, err = 0, element counter = 0, load buffer cleared. Memory is not reset; simulation init sets mem[i] = i.
- instr_ready = 1 only in IDLE. Acceptance = instr_valid & instr_ready at a rising edge. instr is sampled only at acceptance.
- States: IDLE, MEM, EXEC.
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 MUL, 100 SUB, 101-111 illegal.
- LOAD: accept -> MEM, cnt = 0. Each MEM edge captures mem[(addr+cnt) mod DEPTH] (combinational read) into buffer element cnt, then cnt++. The edge capturing element LANES-1 commits the whole buffer to register rsel atomically, pulses done, and returns to IDLE. Busy for exactly LANES cycles after acceptance; the register never shows partial data.
- STORE: accept -> MEM. Each MEM edge writes mem[(addr+cnt) mod DEPTH] = reg[rsel] element cnt. The last-element edge pulses done and returns to IDLE. LANES cycles total.
- Address arithmetic is modulo DEPTH: a vector starting near the top wraps to word 0.
- ALU ops (rsel and addr ignored): accept -> EXEC. The next edge writes A3/A4, pulses done, and returns to IDLE. Results are visible one cycle after acceptance; the next instruction is accepted two edges after the previous one.
- Per lane k, all unsigned:
  - ADD: A3[k] = (A1[k]+A2[k]) mod 2^LANE_W; A4[k] = carry-out, zero-extended.
  - MUL: full 2*LANE_W product; A3[k] = low half, A4[k] = high half.
  - SUB: A3[k] = (A1[k]-A2[k]) mod 2^LANE_W; A4[k] = all-ones if A1[k] < A2[k], else 0.
- Illegal op: accept -> EXEC. The next edge pulses done and err together. No register or memory change.
- Reset mid-LOAD: nothing commits; registers are zeroed. Reset mid-STORE: words already written stay written; the remainder are not written.
- A1/A2 feed ALU ops combinationally but change only on LOAD commit or reset. A3/A4 change only on LOAD commit, ALU retire, or reset.

Test Plan:
1. Reset, then release -> A1..A4 = 0; instr_ready = 1; done = 0; err = 0.
2. LOAD rsel=0, addr=1 -> instr_ready low for 16 cycles; done pulses once on the 16th edge; A1 element k = k+1 (A1 = 0x00000010_..._00000001); A1 stays 0 before commit.
3. LOAD r0 @0, LOAD r1 @1, ADD -> A3[k] = 2k+1, A4 = 0. Then MUL -> A3[k] = k*(k+1), A4 = 0. Then SUB -> A3[k] = 0xFFFFFFFF, A4[k] = 0xFFFFFFFF.
4. Wrap: LOAD r0 @504 -> elements 0..7 = 504..511, elements 8..15 = 0..7. STORE r0 @0x1FC then LOAD r2 @0x1FC -> A3 equals A1 as stored, wrapping through words 0x1FC..0x00B.
5. Reset asserted 5 cycles into a LOAD -> all outputs 0 asynchronously; instr_ready = 1 after release; no done pulse.
6. op=111 with instr_valid held high -> done & err pulse one cycle after acceptance; registers unchanged; a second acceptance occurs on the following edge (back-to-back timing).
